bls_multicycle_sub: RTL

- Parametrised multi-cycle borrow-lookahead subtractor: computes D = A - B - bin on WIDTH-bit operands.
- Processes one SLICE-bit slice per clock, LSB slice first; slice-to-slice borrow is held in a register.
- Inside each slice, borrow uses full lookahead: Gi = Ai'·Bi, Pi = (Ai xor Bi)', Di = (Pi xor Ci)'.
- Sits in the datapath as the area-reduced successor to the fixed 4-bit lookahead subtractor. Adds a start/busy/done handshake plus zero and signed-overflow flags.

---
 rtl/bls_multicycle_sub.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bls_multicycle_sub.sv
// Multi-cycle borrow-lookahead subtractor: D = A - B - bin, one SLICE-bit slice per clock,
// LSB slice first, with start/busy/done handshake and zero / signed-overflow flags.
module bls_multicycle_sub #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);
   // WIDTH must be an integer multiple of SLICE
   localparam int NSLICES = WIDTH / SLICE;
   localparam int KW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, shadow_reg, shadow_next, d_reg;
   logic             a_msb_reg, b_msb_reg, borrow_reg;
   logic             done_reg, bout_reg, zero_reg, ovf_reg;
   logic [KW-1:0]    k_reg;
   logic [SLICE-1:0] sa, sb, g, p, sd;
   logic [SLICE:0]   brw;
   logic             accept, last_step;

   // Operands shift right each cycle so the active slice always sits in the low bits
   assign sa     = a_reg[SLICE-1:0];
   assign sb     = b_reg[SLICE-1:0];
   assign g      = ~sa & sb;
   assign p      = ~(sa ^ sb);
   assign brw[0] = borrow_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SLICE; gi++) begin : g_la
         logic bo;
         logic term;
         // Sum-of-products lookahead: every borrow depends only on g, p and the slice borrow-in
         always_comb begin
            bo   = borrow_reg;
            term = 1'b0;
            for (int j = 0; j <= gi; j++) bo = bo & p[j];
            for (int j = 0; j <= gi; j++) begin
               term = g[j];
               for (int m = j + 1; m <= gi; m++) term = term & p[m];
               bo = bo | term;
            end
         end
         assign brw[gi+1] = bo;
         assign sd[gi]    = ~(p[gi] ^ brw[gi]);
      end
   endgenerate

   // New slice enters at the top; after NSLICES steps the shadow holds the full result
   assign shadow_next = (shadow_reg >> SLICE) | (WIDTH'(sd) << (WIDTH - SLICE));

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (k_reg == KW'(NSLICES - 1)) begin
               last_step  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         borrow_reg <= 1'b0;
         k_reg      <= '0;
         shadow_reg <= '0;
         d_reg      <= '0;
         done_reg   <= 1'b0;
         bout_reg   <= 1'b0;
         zero_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
            borrow_reg <= bin;
            k_reg      <= '0;
            shadow_reg <= '0;
         end else if (state_reg == RUN) begin
            a_reg      <= a_reg >> SLICE;
            b_reg      <= b_reg >> SLICE;
            shadow_reg <= shadow_next;
            borrow_reg <= brw[SLICE];
            k_reg      <= k_reg + 1'b1;
            if (last_step) begin
               d_reg    <= shadow_next;
               bout_reg <= brw[SLICE];
               zero_reg <= (shadow_next == '0);
               ovf_reg  <= (a_msb_reg != b_msb_reg) && (shadow_next[WIDTH-1] != a_msb_reg);
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy = (state_reg == RUN);
   assign done = done_reg;
   assign d    = d_reg;
   assign bout = bout_reg;
   assign zero = zero_reg;
   assign ovf  = ovf_reg;

endmodule
